// File: rtl/imu_burst_reader_pkg.sv
// imu_pkg: definitions shared by the MPU-6050 burst reader and the I2C
// command interface. These are the command codes, the MPU-6050 register
// addresses, the burst length, the sequencer state encoding, and the
// step-table helpers. Each helper maps a step index to the command to
// issue and its byte.
package imu_pkg;

    localparam logic [2:0] CMD_START     = 3'd1;
    localparam logic [2:0] CMD_WRITE     = 3'd2;
    localparam logic [2:0] CMD_READ_ACK  = 3'd4;
    localparam logic [2:0] CMD_READ_NACK = 3'd5;
    localparam logic [2:0] CMD_STOP      = 3'd6;

    localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
    localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] PWR_WAKE_VALUE   = 8'h00;

    localparam int BURST_LEN = 14;

    localparam logic [4:0] WAKE_LAST_STEP       = 5'd3;
    localparam logic [4:0] READ_FIRST_BYTE_STEP = 5'd3;
    localparam logic [4:0] READ_NACK_STEP       = 5'd16;
    localparam logic [4:0] READ_LAST_STEP       = 5'd17;

    typedef enum logic [2:0] {
        ST_BOOT_WAIT,
        ST_WAKE_ISSUE,
        ST_WAKE_WAIT,
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_ERR_STOP_ISSUE,
        ST_ERR_STOP_WAIT
    } state_t;

    typedef struct packed {
        logic [2:0] cmd;
        logic [7:0] data;
    } step_t;

    // Wake: START {addr,W}, WRITE PWR_MGMT_1, WRITE 0x00, STOP
    function automatic step_t wake_step(input logic [4:0] step, input logic [6:0] addr);
        step_t s;
        s.cmd  = CMD_STOP;
        s.data = 8'h00;
        case (step)
            5'd0: begin s.cmd = CMD_START; s.data = {addr, 1'b0}; end
            5'd1: begin s.cmd = CMD_WRITE; s.data = REG_PWR_MGMT_1; end
            5'd2: begin s.cmd = CMD_WRITE; s.data = PWR_WAKE_VALUE; end
            default: ;
        endcase
        return s;
    endfunction

    // Read: START {addr,W}, WRITE 0x3B, START {addr,R}, 13x READ_ACK, READ_NACK, STOP
    function automatic step_t read_step(input logic [4:0] step, input logic [6:0] addr);
        step_t s;
        s.cmd  = CMD_STOP;
        s.data = 8'h00;
        if (step == 5'd0) begin
            s.cmd = CMD_START; s.data = {addr, 1'b0};
        end else if (step == 5'd1) begin
            s.cmd = CMD_WRITE; s.data = REG_ACCEL_XOUT_H;
        end else if (step == 5'd2) begin
            s.cmd = CMD_START; s.data = {addr, 1'b1};
        end else if (step < READ_NACK_STEP) begin
            s.cmd = CMD_READ_ACK;
        end else if (step == READ_NACK_STEP) begin
            s.cmd = CMD_READ_NACK;
        end
        return s;
    endfunction

    // Only address/data phases carry a meaningful ACK.
    function automatic logic cmd_checks_ack(input logic [2:0] cmd);
        return (cmd == CMD_START) || (cmd == CMD_WRITE);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/imu_burst_reader_if.sv
// Command handshake between the burst reader (master) and the
// i2c_master_interface (slave).
//   o_cmd/o_tx_data/o_cmd_valid : command, byte and one-cycle strobe
//   i_rx_data/i_cmd_done/i_cmd_error : completion strobe with byte and error
interface imu_burst_reader_if;
    logic [2:0] o_cmd;
    logic [7:0] o_tx_data;
    logic       o_cmd_valid;
    logic [7:0] i_rx_data;
    logic       i_cmd_done;
    logic       i_cmd_error;

    modport master (
        output o_cmd, o_tx_data, o_cmd_valid,
        input  i_rx_data, i_cmd_done, i_cmd_error
    );

    modport slave (
        input  o_cmd, o_tx_data, o_cmd_valid,
        output i_rx_data, i_cmd_done, i_cmd_error
    );
endinterface

// File: rtl/imu_burst_reader_timer.sv
// imu_sample_timer: free-running sample-rate counter.
//   i_clk, i_rst_n : clock, async active-low reset
//   o_tick         : high for one cycle every SAMPLE_DIV cycles (at wrap)
module imu_sample_timer #(
    parameter int SAMPLE_DIV = 250000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);
    localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign o_tick = (cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (o_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/imu_burst_reader.sv
// imu_burst_reader: wakes the MPU-6050 after a boot delay. It then burst-reads
// the 14 measurement bytes on each sample tick and commits all seven words
// together.
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_enable         : allows sample ticks to start reads
//   i2c              : command handshake towards i2c_master_interface
//   o_accel_*, o_temp, o_gyro_* : signed sample words, big-endian assembled
//   o_sample_valid   : one-cycle pulse when the words update
//   o_ready          : wake sequence completed
//   o_err_count      : saturating count of NACKed START/WRITE phases
//
// state             | meaning
// ST_BOOT_WAIT      | counting down the power-up delay
// ST_WAKE_ISSUE     | strobe the current wake command
// ST_WAKE_WAIT      | wait for the wake command to complete
// ST_IDLE           | awake, waiting for a pending tick with enable high
// ST_RD_ISSUE       | strobe the current read-burst command
// ST_RD_WAIT        | wait for the read command to complete, capture bytes
// ST_ERR_STOP_ISSUE | strobe the STOP that releases the bus after a NACK
// ST_ERR_STOP_WAIT  | wait for that STOP, then retry path
module imu_burst_reader
    import imu_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h68,
    parameter int         SAMPLE_DIV = 250000,
    parameter int         BOOT_DELAY = 2500000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    imu_burst_reader_if.master   i2c,
    output logic [15:0]          o_accel_x,
    output logic [15:0]          o_accel_y,
    output logic [15:0]          o_accel_z,
    output logic [15:0]          o_temp,
    output logic [15:0]          o_gyro_x,
    output logic [15:0]          o_gyro_y,
    output logic [15:0]          o_gyro_z,
    output logic                 o_sample_valid,
    output logic                 o_ready,
    output logic [7:0]           o_err_count
);
    localparam int BOOT_W = (BOOT_DELAY > 2) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LOAD = BOOT_W'(BOOT_DELAY - 1);

    state_t            state;
    logic [4:0]        step;
    logic [BOOT_W-1:0] boot_cnt;
    logic              pending;
    logic [7:0]        shadow [BURST_LEN];

    logic  tick;
    logic  ack_fail;
    logic  is_data_step;
    logic  [3:0] byte_idx;
    step_t wake_cur;
    step_t read_cur;

    imu_sample_timer #(.SAMPLE_DIV(SAMPLE_DIV)) u_timer (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .o_tick (tick)
    );

    assign wake_cur     = wake_step(step, DEV_ADDR);
    assign read_cur     = read_step(step, DEV_ADDR);
    // o_cmd holds the command being waited on, so it tells us whether the error flag counts
    assign ack_fail     = i2c.i_cmd_error && cmd_checks_ack(i2c.o_cmd);
    assign is_data_step = (step >= READ_FIRST_BYTE_STEP) && (step <= READ_NACK_STEP);
    assign byte_idx     = 4'(step - READ_FIRST_BYTE_STEP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_BOOT_WAIT;
            step            <= '0;
            boot_cnt        <= BOOT_LOAD;
            pending         <= 1'b0;
            i2c.o_cmd       <= '0;
            i2c.o_tx_data   <= '0;
            i2c.o_cmd_valid <= 1'b0;
            o_accel_x       <= '0;
            o_accel_y       <= '0;
            o_accel_z       <= '0;
            o_temp          <= '0;
            o_gyro_x        <= '0;
            o_gyro_y        <= '0;
            o_gyro_z        <= '0;
            o_sample_valid  <= 1'b0;
            o_ready         <= 1'b0;
            o_err_count     <= '0;
            for (int i = 0; i < BURST_LEN; i++) shadow[i] <= '0;
        end else begin
            i2c.o_cmd_valid <= 1'b0;
            o_sample_valid  <= 1'b0;
            // Depth-1 tick queue; the IDLE exit below clears it and wins over a same-cycle tick
            if (tick && o_ready) pending <= 1'b1;

            case (state)
                ST_BOOT_WAIT: begin
                    if (boot_cnt == '0) begin
                        state <= ST_WAKE_ISSUE;
                        step  <= '0;
                    end else begin
                        boot_cnt <= boot_cnt - 1'b1;
                    end
                end
                ST_WAKE_ISSUE: begin
                    i2c.o_cmd_valid <= 1'b1;
                    i2c.o_cmd       <= wake_cur.cmd;
                    i2c.o_tx_data   <= wake_cur.data;
                    state           <= ST_WAKE_WAIT;
                end
                ST_WAKE_WAIT: begin
                    if (i2c.i_cmd_done) begin
                        if (ack_fail) begin
                            o_err_count <= sat_inc8(o_err_count);
                            state       <= ST_ERR_STOP_ISSUE;
                        end else if (step == WAKE_LAST_STEP) begin
                            o_ready <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            step  <= step + 5'd1;
                            state <= ST_WAKE_ISSUE;
                        end
                    end
                end
                ST_IDLE: begin
                    if (pending && i_enable) begin
                        pending <= 1'b0;
                        step    <= '0;
                        state   <= ST_RD_ISSUE;
                    end
                end
                ST_RD_ISSUE: begin
                    i2c.o_cmd_valid <= 1'b1;
                    i2c.o_cmd       <= read_cur.cmd;
                    i2c.o_tx_data   <= read_cur.data;
                    state           <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (i2c.i_cmd_done) begin
                        if (ack_fail) begin
                            o_err_count <= sat_inc8(o_err_count);
                            state       <= ST_ERR_STOP_ISSUE;
                        end else begin
                            if (is_data_step) shadow[byte_idx] <= i2c.i_rx_data;
                            if (step == READ_LAST_STEP) begin
                                o_accel_x      <= {shadow[0],  shadow[1]};
                                o_accel_y      <= {shadow[2],  shadow[3]};
                                o_accel_z      <= {shadow[4],  shadow[5]};
                                o_temp         <= {shadow[6],  shadow[7]};
                                o_gyro_x       <= {shadow[8],  shadow[9]};
                                o_gyro_y       <= {shadow[10], shadow[11]};
                                o_gyro_z       <= {shadow[12], shadow[13]};
                                o_sample_valid <= 1'b1;
                                state          <= ST_IDLE;
                            end else begin
                                step  <= step + 5'd1;
                                state <= ST_RD_ISSUE;
                            end
                        end
                    end
                end
                ST_ERR_STOP_ISSUE: begin
                    i2c.o_cmd_valid <= 1'b1;
                    i2c.o_cmd       <= CMD_STOP;
                    i2c.o_tx_data   <= 8'h00;
                    state           <= ST_ERR_STOP_WAIT;
                end
                ST_ERR_STOP_WAIT: begin
                    if (i2c.i_cmd_done) begin
                        step <= '0;
                        // o_ready is only set by a completed wake, so it tells which sequence failed
                        if (o_ready) begin
                            state <= ST_IDLE;
                        end else begin
                            boot_cnt <= BOOT_LOAD;
                            state    <= ST_BOOT_WAIT;
                        end
                    end
                end
                default: state <= ST_BOOT_WAIT;
            endcase
        end
    end
endmodule
